// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the quarter/dime sensors, emits one-cycle
// non-overlapping accept pulses, keeps saturating tallies and sticky per-slot jam flags.
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int JAM_CYC  = 64,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             q_raw,
    input  logic             d_raw,
    output logic             Q_in,
    output logic             D_in,
    output logic [CNT_W-1:0] q_count,
    output logic [CNT_W-1:0] d_count,
    output logic             q_jam,
    output logic             d_jam
);

    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int JAM_W = $clog2(JAM_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HELD,
        FALL,
        JAMMED
    } chan_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Bit 0 is the quarter slot, bit 1 the dime slot throughout.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] acc;
    logic [1:0] jam;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {d_raw, q_raw};
            sync_q <= meta_q;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_chan
        chan_state_e      state_q;
        logic [DB_W-1:0]  db_q;
        logic [JAM_W-1:0] jam_cnt_q;
        logic             acc_q;
        logic             jam_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q   <= IDLE;
                db_q      <= '0;
                jam_cnt_q <= '0;
                acc_q     <= 1'b0;
                jam_q     <= 1'b0;
            end else begin
                acc_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (sync_q[c]) begin
                            state_q <= RISE;
                            db_q    <= DB_W'(1);
                        end
                    end
                    RISE: begin
                        if (!sync_q[c]) begin
                            state_q <= IDLE;
                            db_q    <= '0;
                        end else if (db_q == DB_W'(DEBOUNCE - 1)) begin
                            state_q   <= HELD;
                            db_q      <= '0;
                            jam_cnt_q <= '0;
                            acc_q     <= 1'b1;
                        end else begin
                            db_q <= db_q + DB_W'(1);
                        end
                    end
                    HELD: begin
                        if (!sync_q[c]) begin
                            state_q <= FALL;
                            db_q    <= DB_W'(1);
                        end else if (jam_cnt_q == JAM_W'(JAM_CYC - 1)) begin
                            state_q   <= JAMMED;
                            jam_cnt_q <= JAM_W'(JAM_CYC);
                            jam_q     <= 1'b1;
                        end else begin
                            jam_cnt_q <= jam_cnt_q + JAM_W'(1);
                        end
                    end
                    FALL: begin
                        // A short dropout returns to HELD without a new accept;
                        // the jam count keeps running across it.
                        if (sync_q[c]) begin
                            state_q <= HELD;
                            db_q    <= '0;
                        end else if (db_q == DB_W'(DEBOUNCE - 1)) begin
                            state_q   <= IDLE;
                            db_q      <= '0;
                            jam_cnt_q <= '0;
                        end else begin
                            db_q <= db_q + DB_W'(1);
                        end
                    end
                    JAMMED: state_q <= JAMMED;
                    default: begin
                        state_q <= IDLE;
                        db_q    <= '0;
                    end
                endcase
            end
        end

        assign acc[c] = acc_q;
        assign jam[c] = jam_q;
    end

    logic             q_pulse_q;
    logic             d_pulse_q;
    logic             pend_q_q;
    logic             pend_d_q;
    logic [CNT_W-1:0] q_count_q;
    logic [CNT_W-1:0] d_count_q;

    // A pending pulse always goes out first; a colliding fresh accept is parked instead.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_pulse_q <= 1'b0;
            d_pulse_q <= 1'b0;
            pend_q_q  <= 1'b0;
            pend_d_q  <= 1'b0;
            q_count_q <= '0;
            d_count_q <= '0;
        end else begin
            q_pulse_q <= 1'b0;
            d_pulse_q <= 1'b0;
            if (pend_q_q) begin
                q_pulse_q <= 1'b1;
                q_count_q <= sat_inc(q_count_q);
                pend_q_q  <= acc[0];
                pend_d_q  <= pend_d_q | acc[1];
            end else if (pend_d_q) begin
                d_pulse_q <= 1'b1;
                d_count_q <= sat_inc(d_count_q);
                pend_d_q  <= acc[1];
                pend_q_q  <= acc[0];
            end else if (acc[0]) begin
                q_pulse_q <= 1'b1;
                q_count_q <= sat_inc(q_count_q);
                pend_d_q  <= acc[1];
            end else if (acc[1]) begin
                d_pulse_q <= 1'b1;
                d_count_q <= sat_inc(d_count_q);
            end
        end
    end

    assign Q_in    = q_pulse_q;
    assign D_in    = d_pulse_q;
    assign q_count = q_count_q;
    assign d_count = d_count_q;
    assign q_jam   = jam[0];
    assign d_jam   = jam[1];

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a segment table for pulse/tally behaviour plus
// hand-written sequences for latency, jam, saturation and reset corner cases.
module tb_coin_acceptor;

    localparam int DEBOUNCE = 4;
    localparam int JAM_CYC  = 64;
    localparam int CNT_W    = 8;

    logic             clk   = 1'b0;
    logic             rstn  = 1'b0;
    logic             q_raw = 1'b0;
    logic             d_raw = 1'b0;
    logic             Q_in;
    logic             D_in;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] d_count;
    logic             q_jam;
    logic             d_jam;

    coin_acceptor #(
        .DEBOUNCE(DEBOUNCE),
        .JAM_CYC (JAM_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .q_raw  (q_raw),
        .d_raw  (d_raw),
        .Q_in   (Q_in),
        .D_in   (D_in),
        .q_count(q_count),
        .d_count(d_count),
        .q_jam  (q_jam),
        .d_jam  (d_jam)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_fail   = 0;
    int qp       = 0;
    int dp       = 0;
    int both_cnt = 0;

    typedef struct {
        logic q;
        logic d;
        int   cyc;
        int   exp_qp;
        int   exp_dp;
        int   exp_qc;
        int   exp_dc;
        int   exp_qj;
        int   exp_dj;
    } seg_t;

    seg_t tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (Q_in === 1'b1) qp++;
            if (D_in === 1'b1) dp++;
            if (Q_in === 1'b1 && D_in === 1'b1) both_cnt++;
        end
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        q_raw = 1'b0;
        d_raw = 1'b0;
        step(2);
        rstn = 1'b1;
        step(2);
    endtask

    initial begin
        int jam_at;

        tbl[0]  = '{1'b0, 1'b1, 2,  0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1,  0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 2,  0, 0, 1, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 8,  0, 0, 1, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 10, 0, 1, 1, 1, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 8,  0, 0, 1, 1, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 3,  0, 0, 1, 1, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 8,  0, 0, 1, 1, 0, 0};
        tbl[8]  = '{1'b1, 1'b1, 10, 1, 1, 2, 2, 0, 0};
        tbl[9]  = '{1'b0, 1'b0, 8,  0, 0, 2, 2, 0, 0};
        tbl[10] = '{1'b0, 1'b1, 4,  0, 0, 2, 2, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 8,  0, 1, 2, 3, 0, 0};
        tbl[12] = '{1'b1, 1'b0, 8,  1, 0, 3, 3, 0, 0};
        tbl[13] = '{1'b0, 1'b0, 8,  0, 0, 3, 3, 0, 0};

        // Reset state
        #1;
        chk("rst_Q_in", int'(Q_in), 0);
        chk("rst_D_in", int'(D_in), 0);
        chk("rst_q_count", int'(q_count), 0);
        chk("rst_d_count", int'(d_count), 0);
        chk("rst_q_jam", int'(q_jam), 0);
        chk("rst_d_jam", int'(d_jam), 0);
        step(3);
        rstn = 1'b1;
        step(2);

        // Clean quarter: first sampled at edge k, pulse only after edge k+6
        qp = 0; dp = 0;
        q_raw = 1'b1;
        step(6);
        chk("lat_before", int'(Q_in), 0);
        step(1);
        chk("lat_pulse", int'(Q_in), 1);
        chk("lat_tally", int'(q_count), 1);
        step(1);
        chk("lat_after", int'(Q_in), 0);
        step(12);
        q_raw = 1'b0;
        step(10);
        chk("clean_qp", qp, 1);
        chk("clean_dp", dp, 0);
        chk("clean_q_count", int'(q_count), 1);

        for (int s = 0; s < 14; s++) begin
            qp = 0; dp = 0;
            q_raw = tbl[s].q;
            d_raw = tbl[s].d;
            step(tbl[s].cyc);
            chk($sformatf("seg%0d_qp", s), qp, tbl[s].exp_qp);
            chk($sformatf("seg%0d_dp", s), dp, tbl[s].exp_dp);
            chk($sformatf("seg%0d_q_count", s), int'(q_count), tbl[s].exp_qc);
            chk($sformatf("seg%0d_d_count", s), int'(d_count), tbl[s].exp_dc);
            chk($sformatf("seg%0d_q_jam", s), int'(q_jam), tbl[s].exp_qj);
            chk($sformatf("seg%0d_d_jam", s), int'(d_jam), tbl[s].exp_dj);
        end

        // Simultaneous rise: Q at k+6, D deferred to k+7
        qp = 0; dp = 0;
        q_raw = 1'b1;
        d_raw = 1'b1;
        step(6);
        chk("sim_pre_Q", int'(Q_in), 0);
        chk("sim_pre_D", int'(D_in), 0);
        step(1);
        chk("sim_k6_Q", int'(Q_in), 1);
        chk("sim_k6_D", int'(D_in), 0);
        step(1);
        chk("sim_k7_Q", int'(Q_in), 0);
        chk("sim_k7_D", int'(D_in), 1);
        step(4);
        q_raw = 1'b0;
        d_raw = 1'b0;
        step(10);
        chk("sim_q_count", int'(q_count), 4);
        chk("sim_d_count", int'(d_count), 4);

        // Jam: 64 synced high cycles in HELD after acceptance
        qp = 0; dp = 0;
        jam_at = -1;
        q_raw = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (jam_at < 0 && q_jam === 1'b1) jam_at = i;
        end
        chk("jam_cycle", jam_at, 70);
        chk("jam_qp", qp, 1);
        chk("jam_q_count", int'(q_count), 5);
        q_raw = 1'b0;
        step(10);
        qp = 0; dp = 0;
        q_raw = 1'b1;
        d_raw = 1'b1;
        step(10);
        q_raw = 1'b0;
        d_raw = 1'b0;
        step(10);
        chk("jammed_qp", qp, 0);
        chk("jammed_dp", dp, 1);
        chk("jammed_q_count", int'(q_count), 5);
        chk("jammed_d_count", int'(d_count), 5);
        chk("jammed_q_jam", int'(q_jam), 1);
        chk("jammed_d_jam", int'(d_jam), 0);
        rstn = 1'b0;
        #1;
        chk("jamclr_q_jam", int'(q_jam), 0);
        chk("jamclr_q_count", int'(q_count), 0);
        step(2);
        rstn = 1'b1;
        step(2);

        // Saturation
        qp = 0; dp = 0;
        for (int n = 1; n <= 300; n++) begin
            q_raw = 1'b1;
            step(8);
            q_raw = 1'b0;
            step(8);
            if (n == 254) chk("sat_254", int'(q_count), 254);
            if (n == 256) chk("sat_256", int'(q_count), 255);
        end
        chk("sat_qp", qp, 300);
        chk("sat_q_count", int'(q_count), 255);
        chk("sat_d_count", int'(d_count), 0);

        // Reset two cycles into a rise
        do_reset();
        q_raw = 1'b1;
        step(2);
        rstn  = 1'b0;
        q_raw = 1'b0;
        #1;
        chk("midrst_outs", int'({Q_in, D_in, q_count, d_count, q_jam, d_jam}), 0);
        step(2);
        rstn = 1'b1;
        qp = 0; dp = 0;
        step(15);
        chk("midrst_qp", qp, 0);
        chk("midrst_q_count", int'(q_count), 0);

        // Reset with an accept registered but its pulse not yet out
        q_raw = 1'b1;
        step(6);
        chk("pendrst_pre", int'(Q_in), 0);
        rstn  = 1'b0;
        q_raw = 1'b0;
        step(2);
        rstn = 1'b1;
        qp = 0; dp = 0;
        step(15);
        chk("pendrst_qp", qp, 0);
        chk("pendrst_q_count", int'(q_count), 0);

        chk("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
